// File: rtl/lcd_pkg.sv
// Shared constants and types for the Spartan-3AN character LCD datapath
// (init sequencer and character writer).
package lcd_pkg;

  localparam logic [7:0] SET_DDRAM        = 8'h80;
  localparam logic [7:0] LINE2_BASE       = 8'h40;
  localparam logic [7:0] CMD_FUNCTION_SET = 8'h38;
  localparam logic [7:0] CMD_ENTRY_MODE   = 8'h06;
  localparam logic [7:0] CMD_DISPLAY_ON   = 8'h0C;
  localparam logic [7:0] CMD_CLEAR        = 8'h01;

  localparam int DEF_E_SETUP_CYCLES   = 2;
  localparam int DEF_E_PULSE_CYCLES   = 12;
  localparam int DEF_EXEC_WAIT_CYCLES = 2000;
  localparam int DEF_COLS             = 16;

  // IDLE must stay at zero: it is the LED debug value seen out of reset.
  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_READY      = 4'd1,
    ST_ADDR_SETUP = 4'd2,
    ST_ADDR_PULSE = 4'd3,
    ST_ADDR_WAIT  = 4'd4,
    ST_DATA_SETUP = 4'd5,
    ST_DATA_PULSE = 4'd6,
    ST_DATA_WAIT  = 4'd7
  } writer_state_e;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_PULSE,
    PH_WAIT
  } strobe_phase_e;

  function automatic logic [7:0] ddram_cmd(input logic row, input logic [6:0] col);
    return SET_DDRAM | (row ? LINE2_BASE : 8'h00) | {1'b0, col};
  endfunction

endpackage

// File: rtl/lcd_write_strobe.sv
// One LCD bus write: bus setup with E low, E pulse, then execution wait.
// A single down-counter times all three sub-phases; start may coincide with done.
module lcd_write_strobe
  import lcd_pkg::*;
#(
  parameter int E_SETUP_CYCLES   = DEF_E_SETUP_CYCLES,
  parameter int E_PULSE_CYCLES   = DEF_E_PULSE_CYCLES,
  parameter int EXEC_WAIT_CYCLES = DEF_EXEC_WAIT_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       abort,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] db,
  output logic       step,
  output logic       done,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic [7:0] LCD_DB
);

  localparam int CNT_W = $clog2(EXEC_WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LOAD_SETUP = CNT_W'(E_SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOAD_PULSE = CNT_W'(E_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOAD_WAIT  = CNT_W'(EXEC_WAIT_CYCLES - 1);

  strobe_phase_e    phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             e_q, e_d;
  logic             rs_q, rs_d;
  logic [7:0]       db_q, db_d;

  assign step   = (phase_q != PH_IDLE) && (cnt_q == '0);
  assign done   = step && (phase_q == PH_WAIT);
  assign LCD_E  = e_q;
  assign LCD_RS = rs_q;
  assign LCD_DB = db_q;

  always_comb begin
    // NOTE: every variable gets a default first, so no path can infer a latch.
    phase_d = phase_q;
    cnt_d   = cnt_q;
    e_d     = e_q;
    rs_d    = rs_q;
    db_d    = db_q;
    if (abort) begin
      phase_d = PH_IDLE;
      cnt_d   = '0;
      e_d     = 1'b0;
      rs_d    = 1'b0;
      db_d    = '0;
    end else if (start) begin
      phase_d = PH_SETUP;
      cnt_d   = LOAD_SETUP;
      e_d     = 1'b0;
      rs_d    = rs;
      db_d    = db;
    end else if (phase_q != PH_IDLE) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else begin
        case (phase_q)
          PH_SETUP: begin phase_d = PH_PULSE; cnt_d = LOAD_PULSE; e_d = 1'b1; end
          PH_PULSE: begin phase_d = PH_WAIT;  cnt_d = LOAD_WAIT;  e_d = 1'b0; end
          default:  phase_d = PH_IDLE;
        endcase
      end
    end
  end

  // Async reset also forces E low mid-pulse without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= PH_IDLE;
      cnt_q   <= '0;
      e_q     <= 1'b0;
      rs_q    <= 1'b0;
      db_q    <= '0;
    end else begin
      // NOTE: non-blocking, so every register here samples pre-edge values.
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      e_q     <= e_d;
      rs_q    <= rs_d;
      db_q    <= db_d;
    end
  end

endmodule

// File: rtl/lcd_char_writer.sv
// Character writer: owns the LCD bus once INIT_DONE is high, tracks a 2-line
// cursor and emits Set-DDRAM-Address only when the cursor is not contiguous.
module lcd_char_writer
  import lcd_pkg::*;
#(
  parameter int E_SETUP_CYCLES   = DEF_E_SETUP_CYCLES,
  parameter int E_PULSE_CYCLES   = DEF_E_PULSE_CYCLES,
  parameter int EXEC_WAIT_CYCLES = DEF_EXEC_WAIT_CYCLES,
  parameter int COLS             = DEF_COLS
) (
  input  logic       CLK_50MHZ,
  input  logic       BTN_SOUTH_N,
  input  logic       INIT_DONE,
  input  logic       CHAR_VALID,
  input  logic [7:0] CHAR_DATA,
  output logic       CHAR_READY,
  input  logic       HOME_REQ,
  output logic [7:0] LCD_DB,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic [7:0] LED
);

  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

  writer_state_e    state_q, state_d;
  logic             row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             need_addr_q, need_addr_d;
  logic [7:0]       char_q, char_d;
  logic             ready_q;

  logic       wr_start, wr_rs, wr_step, wr_done;
  logic [7:0] wr_db;

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    need_addr_d = need_addr_q;
    char_d      = char_q;
    wr_start    = 1'b0;
    wr_rs       = 1'b0;
    wr_db       = '0;
    if (!INIT_DONE) begin
      state_d     = ST_IDLE;
      row_d       = 1'b0;
      col_d       = '0;
      need_addr_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_READY;
        ST_READY: begin
          // Home applies first so a same-cycle character lands at address 0x00.
          if (HOME_REQ) begin
            row_d       = 1'b0;
            col_d       = '0;
            need_addr_d = 1'b1;
          end
          if (CHAR_VALID) begin
            char_d   = CHAR_DATA;
            wr_start = 1'b1;
            if (need_addr_d) begin
              wr_db   = ddram_cmd(row_d, 7'(col_d));
              state_d = ST_ADDR_SETUP;
            end else begin
              wr_rs   = 1'b1;
              wr_db   = CHAR_DATA;
              state_d = ST_DATA_SETUP;
            end
          end
        end
        ST_ADDR_SETUP: if (wr_step) state_d = ST_ADDR_PULSE;
        ST_ADDR_PULSE: if (wr_step) state_d = ST_ADDR_WAIT;
        ST_ADDR_WAIT: if (wr_done) begin
          need_addr_d = 1'b0;
          wr_start    = 1'b1;
          wr_rs       = 1'b1;
          wr_db       = char_q;
          state_d     = ST_DATA_SETUP;
        end
        ST_DATA_SETUP: if (wr_step) state_d = ST_DATA_PULSE;
        ST_DATA_PULSE: if (wr_step) state_d = ST_DATA_WAIT;
        ST_DATA_WAIT: if (wr_done) begin
          state_d = ST_READY;
          if (col_q == LAST_COL) begin
            col_d       = '0;
            row_d       = ~row_q;
            need_addr_d = 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_50MHZ or negedge BTN_SOUTH_N) begin
    if (!BTN_SOUTH_N) begin
      state_q     <= ST_IDLE;
      row_q       <= 1'b0;
      col_q       <= '0;
      need_addr_q <= 1'b1;
      char_q      <= '0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      need_addr_q <= need_addr_d;
      char_q      <= char_d;
      ready_q     <= (state_d == ST_READY);
    end
  end

  lcd_write_strobe #(
    .E_SETUP_CYCLES  (E_SETUP_CYCLES),
    .E_PULSE_CYCLES  (E_PULSE_CYCLES),
    .EXEC_WAIT_CYCLES(EXEC_WAIT_CYCLES)
  ) u_strobe (
    .clk   (CLK_50MHZ),
    .rst_n (BTN_SOUTH_N),
    .abort (~INIT_DONE),
    .start (wr_start),
    .rs    (wr_rs),
    .db    (wr_db),
    .step  (wr_step),
    .done  (wr_done),
    .LCD_E (LCD_E),
    .LCD_RS(LCD_RS),
    .LCD_DB(LCD_DB)
  );

  assign CHAR_READY = ready_q;
  assign LCD_RW     = 1'b0;
  assign LED        = {4'b0000, state_q};

endmodule

// File: tb/tb_lcd_char_writer.sv
// Scoreboard bench: a cursor model predicts every LCD bus write at accept time;
// a monitor pops and compares on each rising LCD_E and checks pulse shape.
module tb_lcd_char_writer;

  localparam int SETUP = 2;
  localparam int PULSE = 12;
  localparam int WAIT  = 40;
  localparam int COLS  = 16;
  localparam int PHASE = SETUP + PULSE + WAIT;
  localparam int READY_BOUND = 3 * PHASE + 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       INIT_DONE, CHAR_VALID, HOME_REQ;
  logic [7:0] CHAR_DATA;
  logic       CHAR_READY, LCD_E, LCD_RS, LCD_RW;
  logic [7:0] LCD_DB, LED;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  bit abort_flag = 0;
  logic [8:0] exp_q[$];
  int m_row = 0, m_col = 0;
  bit m_need = 1;

  always #10 clk = ~clk;
  always @(posedge clk) cyc++;

  lcd_char_writer #(
    .E_SETUP_CYCLES(SETUP), .E_PULSE_CYCLES(PULSE),
    .EXEC_WAIT_CYCLES(WAIT), .COLS(COLS)
  ) dut (
    .CLK_50MHZ(clk), .BTN_SOUTH_N(rst_n), .INIT_DONE(INIT_DONE),
    .CHAR_VALID(CHAR_VALID), .CHAR_DATA(CHAR_DATA), .CHAR_READY(CHAR_READY),
    .HOME_REQ(HOME_REQ), .LCD_DB(LCD_DB), .LCD_E(LCD_E), .LCD_RS(LCD_RS),
    .LCD_RW(LCD_RW), .LED(LED)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_home();
    m_row = 0; m_col = 0; m_need = 1;
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!CHAR_READY && n < READY_BOUND) begin
      @(negedge clk);
      n++;
    end
    if (!CHAR_READY) check("ready_timeout", 32'(CHAR_READY), 1);
  endtask

  // Accept one character; the model predicts the resulting bus writes.
  task automatic accept(input logic [7:0] d, input bit home, output int exp_lat);
    wait_ready();
    CHAR_DATA = d; CHAR_VALID = 1'b1; HOME_REQ = home;
    @(posedge clk);
    if (home) model_home();
    exp_lat = PHASE + 1;
    if (m_need) begin
      exp_q.push_back({1'b0, 8'(8'h80 + m_row * 8'h40 + m_col)});
      exp_lat += PHASE;
      m_need = 0;
    end
    exp_q.push_back({1'b1, d});
    m_col++;
    if (m_col == COLS) begin
      m_col = 0; m_row = (m_row + 1) % 2; m_need = 1;
    end
    @(negedge clk);
    CHAR_VALID = 1'b0; HOME_REQ = 1'b0; acc_cyc = cyc;
  endtask

  task automatic wait_lat(input string name, input int exp_lat);
    wait_ready();
    check(name, 32'(cyc - acc_cyc + 1), 32'(exp_lat));
  endtask

  task automatic home_only();
    wait_ready();
    HOME_REQ = 1'b1;
    @(posedge clk);
    model_home();
    @(negedge clk);
    HOME_REQ = 1'b0;
  endtask

  // HOME_REQ while busy must be ignored: the model is left untouched.
  task automatic busy_home();
    repeat ($urandom_range(1, 20)) @(negedge clk);
    HOME_REQ = 1'b1;
    @(negedge clk);
    HOME_REQ = 1'b0;
  endtask

  task automatic wait_pulse(input bit need_rs);
    int n = 0;
    @(negedge clk);
    while (!(LCD_E && (LCD_RS || !need_rs)) && n < READY_BOUND) begin
      @(negedge clk);
      n++;
    end
    if (!LCD_E) check("pulse_timeout", 32'(LCD_E), 1);
  endtask

  initial begin : monitor
    logic e_prev;
    logic [8:0] bus, prev_bus, cap, exp;
    int width, stable;
    bit hold_bad;
    e_prev = 1'b0; prev_bus = '0; cap = '0; width = 0; stable = 0; hold_bad = 0;
    forever begin
      @(negedge clk);
      bus = {LCD_RS, LCD_DB};
      if (bus == prev_bus) stable++; else stable = 0;
      prev_bus = bus;
      if (LCD_E && !e_prev) begin
        check("setup_stable", 32'(stable >= SETUP), 1);
        check("write_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          exp = exp_q.pop_front();
          check("lcd_write", 32'(bus), 32'(exp));
        end
        check("rw_low", 32'(LCD_RW), 0);
        cap = bus; width = 1; hold_bad = 0;
      end else if (LCD_E) begin
        width++;
        if (bus != cap) hold_bad = 1;
      end else if (e_prev) begin
        if (abort_flag) abort_flag = 0;
        else begin
          check("e_width", 32'(width), PULSE);
          check("bus_hold", 32'(hold_bad), 0);
        end
      end
      e_prev = LCD_E;
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: time limit reached after %0d checks", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int lat, bad, r;
    rst_n = 1'b1; INIT_DONE = 1'b0; CHAR_VALID = 1'b1; CHAR_DATA = 8'hA5; HOME_REQ = 1'b0;
    #5 rst_n = 1'b0;
    #1;
    check("rst_lcd_e", 32'(LCD_E), 0);
    check("rst_lcd_rs", 32'(LCD_RS), 0);
    check("rst_lcd_db", 32'(LCD_DB), 0);
    check("rst_lcd_rw", 32'(LCD_RW), 0);
    check("rst_char_ready", 32'(CHAR_READY), 0);
    check("rst_led", 32'(LED), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // INIT_DONE low: a pending request must not be accepted or touch the bus.
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (CHAR_READY || LCD_E || LCD_RS || LCD_DB != 8'h00 || LED != 8'h00) bad++;
    end
    check("idle_without_init", 32'(bad), 0);
    CHAR_VALID = 1'b0;
    INIT_DONE  = 1'b1;

    accept(8'h41, 0, lat);
    wait_lat("first_char_latency", lat);

    // Two full lines plus one: 0xC0 before char 17, 0x80 before char 33.
    home_only();
    for (int i = 0; i < 33; i++) begin
      accept((i < 17) ? 8'(8'h30 + i) : 8'($urandom_range(32, 126)), 0, lat);
      if (i >= 17 && ($urandom_range(0, 2) == 0)) busy_home();
      wait_lat("line_wrap_latency", lat);
    end
    check("sb_drain_wrap", 32'(exp_q.size()), 0);

    // HOME_REQ together with a character at column 5.
    home_only();
    for (int i = 0; i < 5; i++) begin
      accept(8'(8'h61 + i), 0, lat);
      wait_lat("pre_home_latency", lat);
    end
    accept(8'h5A, 1, lat);
    wait_lat("home_valid_latency", lat);
    check("sb_drain_home", 32'(exp_q.size()), 0);

    // INIT_DONE drops in the data pulse: E low next cycle, IDLE, char dropped.
    accept(8'h77, 0, lat);
    wait_pulse(1'b1);
    @(negedge clk);
    check("abort_sb_empty", 32'(exp_q.size()), 0);
    abort_flag = 1'b1;
    INIT_DONE  = 1'b0;
    model_home();
    @(negedge clk);
    check("abort_lcd_e", 32'(LCD_E), 0);
    check("abort_led_idle", 32'(LED), 0);
    check("abort_char_ready", 32'(CHAR_READY), 0);
    repeat (5) @(negedge clk);
    INIT_DONE = 1'b1;
    accept(8'h42, 0, lat);
    wait_lat("post_abort_latency", lat);

    // Asynchronous reset in the middle of an E pulse.
    accept(8'h63, 0, lat);
    wait_pulse(1'b0);
    #3;
    abort_flag = 1'b1;
    rst_n = 1'b0;
    #1;
    check("async_rst_lcd_e", 32'(LCD_E), 0);
    check("async_rst_lcd_db", 32'(LCD_DB), 0);
    check("async_rst_lcd_rs", 32'(LCD_RS), 0);
    check("async_rst_char_ready", 32'(CHAR_READY), 0);
    check("async_rst_led", 32'(LED), 0);
    exp_q.delete();
    model_home();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic with homes in READY and ignored homes while busy.
    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 9);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if (r == 0) begin
        home_only();
      end else begin
        accept(8'($urandom), r == 1, lat);
        if (r == 2) busy_home();
        wait_lat("random_latency", lat);
      end
    end
    wait_ready();
    repeat (4) @(negedge clk);
    check("sb_drain_final", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lcd_char_writer.md
# lcd_char_writer

Character-write stage that sits directly downstream of the LCD power-on initialisation sequencer on the Spartan-3AN Starter Kit character display. Once the sequencer asserts `INIT_DONE`, this block takes ownership of the LCD bus. It accepts characters over a valid/ready handshake and tracks a 2-line cursor. It issues Set-DDRAM-Address commands and data writes with correct `LCD_E` pulse and execution-wait timing.

## Interface
Parameters:
- `E_SETUP_CYCLES`, default 2: cycles that `LCD_DB`/`LCD_RS` are stable with `LCD_E` low before the pulse.
- `E_PULSE_CYCLES`, default 12: `LCD_E` high time, 240 ns at 50 MHz.
- `EXEC_WAIT_CYCLES`, default 2000: post-pulse wait, 40 µs.
- `COLS`, default 16: characters per line.

Ports:
- `CLK_50MHZ` in 1: sole clock.
- `BTN_SOUTH_N` in 1: reset, asynchronous, active-low.
- `INIT_DONE` in 1: upstream init complete; level.
- `CHAR_VALID` in 1: character request.
- `CHAR_DATA` in 8: character code.
- `CHAR_READY` out 1: block can accept a character.
- `HOME_REQ` in 1: single-cycle pulse; move cursor to line 0, column 0.
- `LCD_DB` out 8: LCD data bus.
- `LCD_E` out 1: LCD enable strobe.
- `LCD_RS` out 1: 0 = command, 1 = data.
- `LCD_RW` out 1: tied 0; the block only writes.
- `LED` out 8: debug view of the current state encoding.

## Operation
- Reset values: `LCD_DB`=0x00, `LCD_E`=0, `LCD_RS`=0, `LCD_RW`=0, `CHAR_READY`=0, `LED`=0x00. Cursor is row 0, col 0, and `need_addr`=1.
- The top level muxes the LCD pins: the upstream sequencer drives them while `INIT_DONE`=0, and this block drives them while `INIT_DONE`=1.
- States:
  - IDLE: waits for `INIT_DONE`=1, then goes to READY.
  - READY: `CHAR_READY`=1.
  - ADDR_SETUP, ADDR_PULSE, ADDR_WAIT: address-command write.
  - DATA_SETUP, DATA_PULSE, DATA_WAIT: data write.
- Accept happens on a cycle in READY with `CHAR_VALID`=1.
  - `CHAR_DATA` is latched on that cycle.
  - If `need_addr`=1, go to ADDR_SETUP; otherwise go to DATA_SETUP.
- Address phase:
  - `LCD_RS`=0 and `LCD_DB`=0x80 | addr.
  - addr = col for row 0; addr = 0x40 + col for row 1.
  - At the end of ADDR_WAIT, clear `need_addr` and go to DATA_SETUP.
- Data phase:
  - `LCD_RS`=1 and `LCD_DB`=latched character.
  - At the end of DATA_WAIT, advance the cursor and return to READY.
- Cursor advance:
  - col < `COLS`-1: col+1.
  - col = `COLS`-1: col=0, row toggles (1 wraps to 0), and `need_addr`=1.
- `HOME_REQ` is honoured only in READY: row=0, col=0, `need_addr`=1.
  - If `CHAR_VALID` is also high on that cycle, both take effect. The character is written at address 0x00.
  - `HOME_REQ` is ignored in every other state.
- `INIT_DONE` falling in any state has the following effect on the next edge:
  - The block goes to IDLE with `LCD_E`=0.
  - Any in-flight character is dropped.
  - The cursor goes home and `need_addr`=1.
- `LCD_DB`/`LCD_RS` hold their value through SETUP, PULSE and WAIT. They change only on entry to a SETUP state.

## Timing
- All outputs are registered.
- `CHAR_READY` drops on the cycle after an accept.
- Each write phase lasts `E_SETUP_CYCLES` + `E_PULSE_CYCLES` + `EXEC_WAIT_CYCLES` cycles. With the defaults this is 2014 cycles.
- `LCD_E` is high for exactly `E_PULSE_CYCLES` consecutive cycles per phase.
- Accept-to-READY latency:
  - Data phase only: 2014 + 1 cycles.
  - With an address phase: 4028 + 1 cycles.
- Back-to-back throughput: one character per 2015 cycles when no address phase is needed.
- A single down-counter, sized to `EXEC_WAIT_CYCLES`, is reloaded on each SETUP/PULSE/WAIT entry.
- Reset asserted mid-pulse drives `LCD_E` to 0 asynchronously.

## Structure
- Shared package `lcd_pkg`:
  - LCD command constants: `SET_DDRAM`=0x80, `LINE2_BASE`=0x40, plus the command values used by the init sequencer.
  - Writer state enum.
  - Cycle-count defaults.
- Sub-module `lcd_write_strobe`:
  - Inputs: `start`, `rs`, `db`.
  - Outputs: `done`, `LCD_E`, `LCD_RS`, `LCD_DB`.
  - Owns the SETUP/PULSE/WAIT counter.
  - The parent FSM sequences address and data phases through it.

## Test plan
- Reset, then release with `INIT_DONE`=0 and `CHAR_VALID`=1 -> `CHAR_READY` stays 0 and all LCD outputs stay 0.
- `INIT_DONE`=1, send 0x41:
  - `LCD_DB`=0x80 with RS=0 and one 12-cycle E pulse.
  - Then 0x41 with RS=1 and one E pulse.
  - `CHAR_READY` returns 4029 cycles after the accept.
- Send 17 characters 0x30..0x40:
  - Characters 2–16 have no address phase.
  - Before character 17, command 0xC0 is issued.
  - After 32 characters, the next character is preceded by 0x80.
- `HOME_REQ` and `CHAR_VALID`(0x5A) asserted together at col 5 -> 0x80 is issued, then 0x5A is written.
- Drop `INIT_DONE` during DATA_PULSE -> `LCD_E`=0 on the next cycle, IDLE. On re-assertion the next character is preceded by 0x80.
- Assert `BTN_SOUTH_N` low mid-pulse -> `LCD_E` falls without a clock edge and all outputs return to their reset values.
